sdram_port_arbiter: RTL and testbench

//  Shares one sdram_controller host interface between NUM_PORTS requesters.

---
 rtl/sdram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one sdram_controller host port between NUM_PORTS masters.
// One access in flight: capture, strobe, confirm acceptance via sd_busy, then wait for completion.
`timescale 1ns/1ps
module sdram_port_arbiter #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned HADDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ISSUE_GAP    = 2,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             req_we_i,
  input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             done_o,
  output logic [NUM_PORTS-1:0]             err_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [HADDR_WIDTH-1:0]           sd_wr_addr_o,
  output logic [HADDR_WIDTH-1:0]           sd_rd_addr_o,
  output logic [DATA_WIDTH-1:0]            sd_wr_data_o,
  output logic                             sd_wr_enable_o,
  output logic                             sd_rd_enable_o,
  input  logic [DATA_WIDTH-1:0]            sd_rd_data_i,
  input  logic                             sd_rd_ready_i,
  input  logic                             sd_busy_i
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam int unsigned TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CHECK, ST_WAIT} state_e;

  state_e                 state_q;
  logic [PW-1:0]          rr_q;
  logic [PW-1:0]          port_q;
  logic                   we_q;
  logic [HADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [GW-1:0]          gap_q;
  logic [TW-1:0]          timer_q;
  logic [NUM_PORTS-1:0]   gnt_q;
  logic [NUM_PORTS-1:0]   done_q;
  logic [NUM_PORTS-1:0]   err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   wr_en_q;
  logic                   rd_en_q;

  logic                   sel_valid_d;
  logic [PW-1:0]          sel_port_d;
  logic [PW-1:0]          rr_d;

  // First requesting port at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    sel_valid_d = 1'b0;
    sel_port_d  = '0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      idx = PW'((32'(rr_q) + off) % NUM_PORTS);
      if (!sel_valid_d && req_i[idx]) begin
        sel_valid_d = 1'b1;
        sel_port_d  = idx;
      end
    end
    rr_d = (sel_port_d == PW'(NUM_PORTS - 1)) ? '0 : PW'(sel_port_d + PW'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      port_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gap_q   <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Strobe is registered on entry so it is visible exactly while in ISSUE.
          if (sel_valid_d && !sd_busy_i) begin
            port_q  <= sel_port_d;
            we_q    <= req_we_i[sel_port_d];
            addr_q  <= req_addr_i[32'(sel_port_d)*HADDR_WIDTH +: HADDR_WIDTH];
            wdata_q <= req_wdata_i[32'(sel_port_d)*DATA_WIDTH +: DATA_WIDTH];
            gnt_q   <= NUM_PORTS'(1) << sel_port_d;
            rr_q    <= rr_d;
            wr_en_q <= req_we_i[sel_port_d];
            rd_en_q <= !req_we_i[sel_port_d];
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          gap_q   <= GW'(ISSUE_GAP);
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          // Busy low after the gap means the controller dropped the command.
          if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
          end else if (sd_busy_i) begin
            timer_q <= '0;
            state_q <= ST_WAIT;
          end else begin
            wr_en_q <= we_q;
            rd_en_q <= !we_q;
            state_q <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (!we_q && sd_rd_ready_i) begin
            rdata_q <= sd_rd_data_i;
            done_q  <= NUM_PORTS'(1) << port_q;
            state_q <= ST_IDLE;
          end else if (we_q && !sd_busy_i) begin
            done_q  <= NUM_PORTS'(1) << port_q;
            state_q <= ST_IDLE;
          end else if (timer_q == TW'(WAIT_TIMEOUT - 1)) begin
            err_q   <= NUM_PORTS'(1) << port_q;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o          = gnt_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign rdata_o        = rdata_q;
  assign sd_wr_addr_o   = addr_q;
  assign sd_rd_addr_o   = addr_q;
  assign sd_wr_data_o   = wdata_q;
  assign sd_wr_enable_o = wr_en_q;
  assign sd_rd_enable_o = rd_en_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: event-timed reference model, a small controller model
// and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int unsigned NP  = 2;
  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned GAP = 2;
  localparam int unsigned WT  = 30;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_i, req_we_i;
  logic [NP*AW-1:0]  req_addr_i;
  logic [NP*DW-1:0]  req_wdata_i;
  logic [NP-1:0]     gnt_o, done_o, err_o;
  logic [DW-1:0]     rdata_o;
  logic [AW-1:0]     sd_wr_addr_o, sd_rd_addr_o;
  logic [DW-1:0]     sd_wr_data_o;
  logic              sd_wr_enable_o, sd_rd_enable_o;
  logic [DW-1:0]     sd_rd_data_i;
  logic              sd_rd_ready_i, sd_busy_i;

  sdram_port_arbiter #(.NUM_PORTS(NP), .HADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .ISSUE_GAP(GAP), .WAIT_TIMEOUT(WT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .sd_wr_addr_o(sd_wr_addr_o), .sd_rd_addr_o(sd_rd_addr_o),
    .sd_wr_data_o(sd_wr_data_o), .sd_wr_enable_o(sd_wr_enable_o),
    .sd_rd_enable_o(sd_rd_enable_o), .sd_rd_data_i(sd_rd_data_i),
    .sd_rd_ready_i(sd_rd_ready_i), .sd_busy_i(sd_busy_i));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;

  // Reference model: the access in flight, described by the cycle it was issued/accepted.
  bit            m_out, m_acc, m_we;
  int            m_port, m_rr, m_issue, m_wstart, m_gnt_port;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rdata;

  // Controller model.
  bit            ctl_active, ctl_we, ctl_busy, ctl_drop, ctl_noready;
  int            ctl_age, refresh_cnt, rel_step;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] mem [logic [AW-1:0]];

  // Observations of the DUT for scenario-level checks.
  int            glog[$];
  int            cnt_wr, cnt_rd, cnt_done, cnt_err, first_gnt, first_en, err_step, err_port;
  logic [DW-1:0] last_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic clear_obs();
    glog.delete();
    cnt_wr = 0; cnt_rd = 0; cnt_done = 0; cnt_err = 0;
    first_gnt = -1; first_en = -1; err_step = -1; err_port = -1;
  endtask

  task automatic drive_reqs();
    req_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0;
    if (q0.size() > 0) begin
      req_i[0] = 1'b1; req_we_i[0] = q0[0].we;
      req_addr_i[0*AW +: AW] = q0[0].addr; req_wdata_i[0*DW +: DW] = q0[0].data;
    end
    if (q1.size() > 0) begin
      req_i[1] = 1'b1; req_we_i[1] = q1[0].we;
      req_addr_i[1*AW +: AW] = q1[0].addr; req_wdata_i[1*DW +: DW] = q1[0].data;
    end
  endtask

  task automatic push(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    if (p == 0) q0.push_back(t); else q1.push_back(t);
    drive_reqs();
  endtask

  // Expected outputs for the current cycle from the inputs sampled at its opening edge.
  task automatic model_and_check();
    logic [NP-1:0] e_gnt, e_done, e_err;
    logic          e_wr, e_rd;
    int            p;
    e_gnt = '0; e_done = '0; e_err = '0; e_wr = 1'b0; e_rd = 1'b0;
    m_gnt_port = -1;
    p = -1;
    if (rst_i) begin
      m_out = 0; m_acc = 0; m_rr = 0; m_we = 0;
      m_rdata = '0; m_addr = '0; m_data = '0;
    end else if (!m_out) begin
      if (req_i != '0 && !sd_busy_i) begin
        for (int k = 0; k < NP; k++)
          if (p < 0 && req_i[(m_rr + k) % NP]) p = (m_rr + k) % NP;
        m_port = p; m_gnt_port = p;
        m_we   = req_we_i[p];
        m_addr = req_addr_i[p*AW +: AW];
        m_data = req_wdata_i[p*DW +: DW];
        m_rr   = (p + 1) % NP;
        m_out  = 1; m_acc = 0; m_issue = step;
        e_gnt[p] = 1'b1; e_wr = m_we; e_rd = !m_we;
      end
    end else if (!m_acc) begin
      if (step == m_issue + int'(GAP) + 2) begin
        if (sd_busy_i) begin
          m_acc = 1; m_wstart = step;
        end else begin
          m_issue = step; e_wr = m_we; e_rd = !m_we;
        end
      end
    end else begin
      if (!m_we && sd_rd_ready_i) begin
        e_done[m_port] = 1'b1; m_rdata = sd_rd_data_i; m_out = 0;
      end else if (m_we && !sd_busy_i) begin
        e_done[m_port] = 1'b1; m_out = 0;
      end else if (step - 1 - m_wstart == int'(WT) - 1) begin
        e_err[m_port] = 1'b1; m_out = 0;
      end
    end
    chk("gnt", gnt_o, e_gnt);
    chk("done", done_o, e_done);
    chk("err", err_o, e_err);
    chk("wr_en", sd_wr_enable_o, e_wr);
    chk("rd_en", sd_rd_enable_o, e_rd);
    chk("rdata", rdata_o, m_rdata);
    chk("wr_addr", sd_wr_addr_o, m_addr);
    chk("rd_addr", sd_rd_addr_o, m_addr);
    chk("wr_data", sd_wr_data_o, m_data);
  endtask

  task automatic stim_update();
    if (m_gnt_port == 0) void'(q0.pop_front());
    if (m_gnt_port == 1) void'(q1.pop_front());
    for (int i = 0; i < NP; i++) begin
      if (gnt_o[i]) begin
        glog.push_back(i);
        if (first_gnt < 0) first_gnt = step;
      end
      if (err_o[i]) begin err_step = step; err_port = i; end
    end
    if (sd_wr_enable_o) cnt_wr++;
    if (sd_rd_enable_o) cnt_rd++;
    if ((sd_wr_enable_o || sd_rd_enable_o) && first_en < 0) first_en = step;
    if (done_o != '0) begin cnt_done++; last_rdata = rdata_o; end
    if (err_o != '0) cnt_err++;
    // Controller: busy one cycle after a taken strobe; reads return data at age 5 with a busy tail.
    sd_rd_ready_i = 1'b0;
    if (ctl_active) begin
      ctl_age++;
      if (ctl_we) begin
        ctl_busy = (ctl_age < 6);
        if (ctl_age >= 6) ctl_active = 0;
      end else begin
        if (ctl_age == 5) begin
          sd_rd_ready_i = !ctl_noready;
          sd_rd_data_i  = mem.exists(ctl_addr) ? mem[ctl_addr] : '0;
        end
        ctl_busy = (ctl_age < 8);
        if (ctl_age >= 8) ctl_active = 0;
      end
    end else if (sd_wr_enable_o || sd_rd_enable_o) begin
      if (ctl_drop) ctl_drop = 0;
      else begin
        ctl_active = 1; ctl_age = 0; ctl_we = sd_wr_enable_o; ctl_busy = 1;
        ctl_addr = sd_wr_enable_o ? sd_wr_addr_o : sd_rd_addr_o;
        if (sd_wr_enable_o) mem[sd_wr_addr_o] = sd_wr_data_o;
      end
    end
    if (refresh_cnt > 0) begin
      if (refresh_cnt == 1) rel_step = step;
      refresh_cnt--;
    end
    sd_busy_i = ctl_busy || (refresh_cnt > 0);
    drive_reqs();
  endtask

  task automatic tick();
    @(negedge clk_i);
    model_and_check();
    stim_update();
    step++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_out || ctl_active || refresh_cnt > 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout after %0d cycles", name, budget);
    end
    tick();
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0;
    sd_rd_data_i = '0; sd_rd_ready_i = 1'b0; sd_busy_i = 1'b0;
    ctl_active = 0; ctl_busy = 0; ctl_drop = 0; ctl_noready = 0; refresh_cnt = 0; rel_step = -1;
    last_rdata = '0;
    clear_obs();
    repeat (3) tick();
    chk("reset_outputs", {gnt_o, done_o, err_o, sd_wr_enable_o, sd_rd_enable_o}, 0);
    chk("reset_addr", sd_wr_addr_o, 0);
    rst_i = 1'b0;
    tick();

    // Both ports held with three reads each: grants must alternate from port 0.
    clear_obs();
    mem[24'h000200] = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 24'h000100 + 24'(i), '0);
      push(1, 1'b0, 24'h000200 + 24'(i), '0);
    end
    wait_idle("t2_rr", 400);
    chk("t2_grants", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) chk("t2_order", glog[i], i % 2);
    chk("t2_dones", cnt_done, 6);

    // Write then read back on port 0.
    clear_obs();
    push(0, 1'b1, 24'h000123, 16'hBEEF);
    wait_idle("t1_write", 100);
    chk("t1_wr_strobes", cnt_wr, 1);
    chk("t1_rd_strobes", cnt_rd, 0);
    chk("t1_write_done", cnt_done, 1);
    push(0, 1'b0, 24'h000123, '0);
    wait_idle("t1_read", 100);
    chk("t1_read_done", cnt_done, 2);
    chk("t1_rdata", last_rdata, 16'hBEEF);
    chk("t1_rdata_hold", rdata_o, 16'hBEEF);

    // Refresh holds busy high: no grant until it drops, then grant on the next cycle.
    clear_obs();
    refresh_cnt = 8; sd_busy_i = 1'b1;
    push(1, 1'b1, 24'h0000F0, 16'h0F0F);
    wait_idle("t3_refresh", 100);
    chk("t3_gnt_latency", first_gnt - rel_step, 1);
    chk("t3_done", cnt_done, 1);

    // First strobe ignored by the controller: re-issued once, completed once.
    clear_obs();
    ctl_drop = 1;
    push(1, 1'b1, 24'h3ABCDE, 16'h5A5A);
    wait_idle("t4_retry", 100);
    chk("t4_wr_strobes", cnt_wr, 2);
    chk("t4_done", cnt_done, 1);
    chk("t4_err", cnt_err, 0);

    // Read accepted but data never returned: timeout error, then next request served.
    clear_obs();
    ctl_noready = 1;
    push(0, 1'b0, 24'h000123, '0);
    wait_idle("t5_timeout", 200);
    chk("t5_err", cnt_err, 1);
    chk("t5_no_done", cnt_done, 0);
    chk("t5_err_port", err_port, 0);
    chk("t5_err_time", err_step - first_en, GAP + 2 + WT);
    ctl_noready = 0;
    push(1, 1'b1, 24'h000044, 16'h4444);
    wait_idle("t5_recover", 100);
    chk("t5_recover_done", cnt_done, 1);

    // Reset while waiting on a write: everything clears and no completion appears.
    clear_obs();
    push(0, 1'b1, 24'h0000AA, 16'hAAAA);
    for (int n = 0; n < 30 && !m_acc; n++) tick();
    chk("t6_accepted", m_acc, 1);
    tick();
    q0.delete(); q1.delete();
    ctl_active = 0; ctl_busy = 0; sd_busy_i = 1'b0; sd_rd_ready_i = 1'b0;
    drive_reqs();
    rst_i = 1'b1;
    tick();
    chk("t6_rst_pulses", {gnt_o, done_o, err_o}, 0);
    chk("t6_rst_strobes", {sd_wr_enable_o, sd_rd_enable_o}, 0);
    chk("t6_rst_rdata", rdata_o, 0);
    chk("t6_rst_capture", {sd_wr_addr_o, sd_wr_data_o}, 0);
    rst_i = 1'b0;
    clear_obs();
    repeat (10) tick();
    chk("t6_no_done", cnt_done, 0);
    chk("t6_no_err", cnt_err, 0);
    push(0, 1'b0, 24'h000010, '0);
    push(1, 1'b0, 24'h000020, '0);
    wait_idle("t6_after", 200);
    chk("t6_rr_reset", glog[0], 0);
    chk("t6_dones", cnt_done, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
